// File: rtl/reg_bank_4x20.sv
// ----------------------------------------------------------------------------
// reg_bank_4x20
// 4-entry x 20-bit register bank feeding the 20-bit 2:1/4:1 datapath muxes.
// Two registered read ports, one valid/ready write port, and a sequential
// clear engine that zeroes one entry per cycle while stalling writes.
//
// Optional feature macro: REG_BANK_BYPASS_EN
//   defined   : write-first reads (same-cycle write/clear visible on read)
//   undefined : read-first reads (value before this cycle's write/clear)
//
// Ports
//   clk       in   1       rising-edge clock
//   rst       in   1       asynchronous active-high reset
//   wr_valid  in   1       write request
//   wr_ready  out  1       bank can accept a write this cycle (combinational)
//   wr_addr   in   ADDR_W  write address
//   wr_data   in   WIDTH   write data
//   rd0_addr  in   ADDR_W  read port 0 address
//   rd0_data  out  WIDTH   read port 0 data (registered)
//   rd1_addr  in   ADDR_W  read port 1 address
//   rd1_data  out  WIDTH   read port 1 data (registered)
//   clr       in   1       start clear sweep (sampled in IDLE only)
//   busy      out  1       clear sweep in progress
//   clr_done  out  1       one-cycle pulse after last entry cleared
// ----------------------------------------------------------------------------
module reg_bank_4x20 #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [WIDTH-1:0]  rd0_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [WIDTH-1:0]  rd1_data,
    input  logic              clr,
    output logic              busy,
    output logic              clr_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              wr_en;
    logic              sweep_on;
    logic [WIDTH-1:0]  rd0_next;
    logic [WIDTH-1:0]  rd1_next;

    // A pending clr takes priority over a same-cycle write, so it drops ready.
    assign wr_ready = ~rst & (state == IDLE) & ~clr;
    assign wr_en    = wr_valid & wr_ready;
    assign sweep_on = (state == SWEEP);

    // Clear-engine FSM: ptr walks 0..DEPTH-1, then a single clr_done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= SWEEP;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (ptr == LAST_IDX) begin
                        state    <= IDLE;
                        ptr      <= '0;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: sweep clear and writes are mutually exclusive (ready is low in SWEEP).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (sweep_on) begin
            mem[ptr] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-port next values; the bypass build forwards this cycle's update.
    always_comb begin
        rd0_next = mem[rd0_addr];
        rd1_next = mem[rd1_addr];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en && (wr_addr == rd0_addr)) begin
            rd0_next = wr_data;
        end
        if (wr_en && (wr_addr == rd1_addr)) begin
            rd1_next = wr_data;
        end
        if (sweep_on && (ptr == rd0_addr)) begin
            rd0_next = '0;
        end
        if (sweep_on && (ptr == rd1_addr)) begin
            rd1_next = '0;
        end
`endif
    end

    // Registered read ports, one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd0_data <= '0;
            rd1_data <= '0;
        end else begin
            rd0_data <= rd0_next;
            rd1_data <= rd1_next;
        end
    end

endmodule

// File: tb/tb_reg_bank_4x20.sv
module tb_reg_bank_4x20;

    localparam int unsigned WIDTH  = 20;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd0_addr;
    logic [WIDTH-1:0]  rd0_data;
    logic [ADDR_W-1:0] rd1_addr;
    logic [WIDTH-1:0]  rd1_data;
    logic              clr;
    logic              busy;
    logic              clr_done;

    always #5 clk = ~clk;

    reg_bank_4x20 dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd0_addr (rd0_addr),
        .rd0_data (rd0_data),
        .rd1_addr (rd1_addr),
        .rd1_data (rd1_data),
        .clr      (clr),
        .busy     (busy),
        .clr_done (clr_done)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: array contents, cycles of sweep remaining, done flag.
    logic [WIDTH-1:0] mem_m [DEPTH];
    int               sweep_left;
    bit               done_m;
    int               done_seen;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        sweep_left = 0;
        done_m     = 1'b0;
    endtask

    // One clock cycle: inputs already driven (at negedge); checks, then returns at next negedge.
    task automatic tick();
        logic [WIDTH-1:0] e0;
        logic [WIDTH-1:0] e1;
        bit               acc;
        int               idx;
        #1;
        chk1("wr_ready", wr_ready, (sweep_left == 0) && !clr);
        acc = wr_valid && (sweep_left == 0) && !clr;
        idx = DEPTH - sweep_left;
        e0  = mem_m[rd0_addr];
        e1  = mem_m[rd1_addr];
`ifdef REG_BANK_BYPASS_EN
        if (acc && wr_addr == rd0_addr) e0 = wr_data;
        if (acc && wr_addr == rd1_addr) e1 = wr_data;
        if (sweep_left > 0 && idx == int'(rd0_addr)) e0 = '0;
        if (sweep_left > 0 && idx == int'(rd1_addr)) e1 = '0;
`endif
        done_m = 1'b0;
        if (sweep_left > 0) begin
            mem_m[idx] = '0;
            sweep_left--;
            if (sweep_left == 0) done_m = 1'b1;
        end else if (clr) begin
            sweep_left = DEPTH;
        end else if (acc) begin
            mem_m[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
        chk("rd0_data", rd0_data, e0);
        chk("rd1_data", rd1_data, e1);
        chk1("busy", busy, sweep_left > 0);
        chk1("clr_done", clr_done, done_m);
        if (clr_done === 1'b1) done_seen++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] pre;

        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd0_addr = '0; rd1_addr = '0; clr = 1'b0;
        model_reset();
        done_seen = 0;
        #2;
        chk("reset rd0", rd0_data, '0);
        chk("reset rd1", rd1_data, '0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset clr_done", clr_done, 1'b0);
        chk1("reset wr_ready", wr_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: write 0xABCDE to addr 2, then read it back on rd0; rd1 on addr 0.
        wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 20'hABCDE;
        tick();
        idle_inputs(); rd0_addr = 2'd2; rd1_addr = 2'd0;
        tick();
        chk("t1 rd0", rd0_data, 20'hABCDE);
        chk("t1 rd1", rd1_data, 20'h00000);

        // 2: back-to-back writes to all entries, then read all back.
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1; wr_addr = ADDR_W'(i);
            wr_data  = (i == 3) ? 20'hFFFFF : WIDTH'(i + 1);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            rd0_addr = ADDR_W'(i); rd1_addr = ADDR_W'(DEPTH - 1 - i);
            tick();
            chk("t2 rd0", rd0_data, (i == 3) ? 20'hFFFFF : WIDTH'(i + 1));
        end

        // 3: same-cycle read/write of addr 1.
        wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 20'h12345;
        tick();
        wr_data = 20'h54321; rd0_addr = 2'd1; rd1_addr = 2'd1;
        tick();
`ifdef REG_BANK_BYPASS_EN
        pre = 20'h54321;
`else
        pre = 20'h12345;
`endif
        chk("t3 rd0 same-cycle", rd0_data, pre);
        idle_inputs();
        tick();
        chk("t3 rd0 after", rd0_data, 20'h54321);

        // 4: clear sweep over a fully nonzero bank.
        done_seen = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd0_addr = ADDR_W'(i); rd1_addr = ADDR_W'(i);
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd0_addr = ADDR_W'(i); rd1_addr = 2'd3;
            tick();
            chk("t4 rd0 cleared", rd0_data, '0);
        end
        chk("t4 clr_done pulses", WIDTH'(done_seen), WIDTH'(1));

        // 5: clr and write in the same cycle; write held and lands after sweep.
        clr = 1'b1; wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 20'h0AAAA;
        tick();
        clr = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        idle_inputs(); rd0_addr = 2'd3;
        tick();
        chk("t5 entry3", rd0_data, 20'h0AAAA);

        // 6: reset during the second sweep cycle.
        done_seen = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0; rd0_addr = 2'd3; rd1_addr = 2'd1;
        tick();
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6 rst rd0", rd0_data, '0);
        chk("t6 rst rd1", rd1_data, '0);
        chk1("t6 rst busy", busy, 1'b0);
        chk1("t6 rst clr_done", clr_done, 1'b0);
        chk1("t6 rst wr_ready", wr_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            rd0_addr = ADDR_W'(i % DEPTH); rd1_addr = 2'd3;
            tick();
        end
        chk("t6 no clr_done", WIDTH'(done_seen), WIDTH'(0));

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = ADDR_W'($urandom);
            wr_data  = WIDTH'($urandom);
            rd0_addr = ADDR_W'($urandom);
            rd1_addr = ADDR_W'($urandom);
            clr      = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < DEPTH + 2; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
